// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite MMIO bridge: response codes, MMIO
// register offsets and FSM state encodings.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte offsets inside the MMIO window
  localparam int unsigned CTRL_OFF     = 32'h000;
  localparam int unsigned SNAP_OFF     = 32'h004;
  localparam int unsigned CNT_BASE_OFF = 32'h040;

  typedef enum logic [1:0] {
    W_IDLE,
    W_EXEC,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_EXEC,
    R_WAIT,
    R_RESP
  } rd_state_e;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_mem_arb.sv
// Two-requester round-robin arbiter for the shared memory port.
// A lone requester is granted at once; on a tie the side opposite the
// last grant wins. Priority starts on the write side.
module axi_lite_mem_arb (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESET,
  input  logic wr_req,
  input  logic rd_req,
  output logic wr_gnt,
  output logic rd_gnt
);

  logic prio_wr;

  // Grant decode; the two grants are mutually exclusive by construction
  always_comb begin
    wr_gnt = wr_req && (!rd_req || prio_wr);
    rd_gnt = rd_req && (!wr_req || !prio_wr);
  end

  // Last-grant register: favour the other side next time
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      prio_wr <= 1'b1;
    end else if (wr_gnt) begin
      prio_wr <= 1'b0;
    end else if (rd_gnt) begin
      prio_wr <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_mmio_bridge.sv
// AXI4-Lite slave giving the ARM side access to MIPS memory (lower window)
// and to MIPS control/status registers (upper window).
module axi_lite_mmio_bridge
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned MEM_RD_LATENCY = 1,
  parameter int unsigned NUM_CNT        = 8,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [ADDR_WIDTH-1:0]         S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]         S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [ADDR_WIDTH-3:0]         AXI_Address,
  output logic [31:0]                   AXI_Write_data,
  output logic [3:0]                    AXI_Write_strb,
  output logic                          AXI_MemWrite,
  output logic                          AXI_MemRead,
  input  logic [31:0]                   AXI_Read_data,
  input  logic [NUM_CNT*CNT_WIDTH-1:0]  cnt_bus,
  output logic                          mips_rst
);

  localparam logic [1:0] RD_LAT = 2'(MEM_RD_LATENCY);

  // Write channel state
  wr_state_e             w_state, w_state_n;
  logic                  aw_held, aw_held_n, w_held, w_held_n;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_n;
  logic [31:0]           wdata_q, wdata_n;
  logic [3:0]            wstrb_q, wstrb_n;
  logic                  awready_q, awready_n, wready_q, wready_n;
  logic                  bvalid_q, bvalid_n;
  logic [1:0]            bresp_q, bresp_n;

  // Read channel state
  rd_state_e             r_state, r_state_n;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_n;
  logic                  arready_q, arready_n, rvalid_q, rvalid_n;
  logic [1:0]            rresp_q, rresp_n;
  logic [31:0]           rdata_q, rdata_n;
  logic [1:0]            wait_cnt, wait_cnt_n;

  // MMIO registers
  logic                  mips_rst_q;
  logic [CNT_WIDTH-1:0]  shadow [NUM_CNT];

  // Decode and arbitration
  logic                  w_is_mmio, r_is_mmio;
  logic [31:0]           w_off, r_off;
  logic                  w_hit_ctrl, w_hit_snap, w_mmio_go;
  logic [31:0]           r_mmio_data;
  logic                  r_mmio_err;
  logic                  wr_req, rd_req, wr_gnt, rd_gnt;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{waddr_q[1:0], raddr_q[1:0]};

  assign w_is_mmio  = waddr_q[ADDR_WIDTH-1];
  assign r_is_mmio  = raddr_q[ADDR_WIDTH-1];
  assign w_off      = 32'({waddr_q[ADDR_WIDTH-2:2], 2'b00});
  assign r_off      = 32'({raddr_q[ADDR_WIDTH-2:2], 2'b00});
  assign w_hit_ctrl = (w_off == CTRL_OFF);
  assign w_hit_snap = (w_off == SNAP_OFF);
  assign w_mmio_go  = (w_state == W_EXEC) && w_is_mmio;

  assign wr_req = (w_state == W_EXEC) && !w_is_mmio;
  assign rd_req = (r_state == R_EXEC) && !r_is_mmio;

  axi_lite_mem_arb u_arb (
    .S_AXI_ACLK   (S_AXI_ACLK),
    .S_AXI_ARESET (S_AXI_ARESET),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .wr_gnt       (wr_gnt),
    .rd_gnt       (rd_gnt)
  );

  // Memory port: driven only by the granted side, idle value zero
  always_comb begin
    AXI_MemWrite   = wr_gnt;
    AXI_MemRead    = rd_gnt;
    AXI_Address    = '0;
    AXI_Write_data = '0;
    AXI_Write_strb = '0;
    if (wr_gnt) begin
      AXI_Address    = waddr_q[ADDR_WIDTH-2:2];
      AXI_Write_data = wdata_q;
      AXI_Write_strb = wstrb_q;
    end else if (rd_gnt) begin
      AXI_Address    = raddr_q[ADDR_WIDTH-2:2];
    end
  end

  // MMIO read mux; anything unmapped reports an error with zero data
  always_comb begin
    r_mmio_data = '0;
    r_mmio_err  = 1'b1;
    if (r_off == CTRL_OFF) begin
      r_mmio_data = {31'b0, ~mips_rst_q};
      r_mmio_err  = 1'b0;
    end else if (r_off == SNAP_OFF) begin
      r_mmio_err  = 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        if (r_off == CNT_BASE_OFF + 32'd4 * i) begin
          r_mmio_data = 32'(shadow[i]);
          r_mmio_err  = 1'b0;
        end
      end
    end
  end

  // Write FSM next state: AW and W are captured independently in idle
  always_comb begin
    w_state_n = w_state;
    aw_held_n = aw_held;
    w_held_n  = w_held;
    waddr_n   = waddr_q;
    wdata_n   = wdata_q;
    wstrb_n   = wstrb_q;
    bvalid_n  = bvalid_q;
    bresp_n   = bresp_q;
    unique case (w_state)
      W_IDLE: begin
        if (S_AXI_AWVALID && awready_q) begin
          aw_held_n = 1'b1;
          waddr_n   = S_AXI_AWADDR;
        end
        if (S_AXI_WVALID && wready_q) begin
          w_held_n = 1'b1;
          wdata_n  = S_AXI_WDATA;
          wstrb_n  = S_AXI_WSTRB;
        end
        if (aw_held_n && w_held_n) begin
          w_state_n = W_EXEC;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
        end
      end
      W_EXEC: begin
        if (w_is_mmio) begin
          bvalid_n  = 1'b1;
          bresp_n   = resp_of(!(w_hit_ctrl || w_hit_snap));
          w_state_n = W_RESP;
        end else if (wr_gnt) begin
          bvalid_n  = 1'b1;
          bresp_n   = RESP_OKAY;
          w_state_n = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_n  = 1'b0;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
    // Ready outputs are registered, so they are derived from next state
    awready_n = (w_state_n == W_IDLE) && !aw_held_n;
    wready_n  = (w_state_n == W_IDLE) && !w_held_n;
  end

  // Write FSM registers
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state   <= w_state_n;
      aw_held   <= aw_held_n;
      w_held    <= w_held_n;
      waddr_q   <= waddr_n;
      wdata_q   <= wdata_n;
      wstrb_q   <= wstrb_n;
      awready_q <= awready_n;
      wready_q  <= wready_n;
      bvalid_q  <= bvalid_n;
      bresp_q   <= bresp_n;
    end
  end

  // Read FSM next state: memory reads wait out the read latency
  always_comb begin
    r_state_n  = r_state;
    raddr_n    = raddr_q;
    rvalid_n   = rvalid_q;
    rresp_n    = rresp_q;
    rdata_n    = rdata_q;
    wait_cnt_n = wait_cnt;
    unique case (r_state)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          raddr_n   = S_AXI_ARADDR;
          r_state_n = R_EXEC;
        end
      end
      R_EXEC: begin
        if (r_is_mmio) begin
          rdata_n   = r_mmio_data;
          rresp_n   = resp_of(r_mmio_err);
          rvalid_n  = 1'b1;
          r_state_n = R_RESP;
        end else if (rd_gnt) begin
          if (MEM_RD_LATENCY == 0) begin
            rdata_n   = AXI_Read_data;
            rresp_n   = RESP_OKAY;
            rvalid_n  = 1'b1;
            r_state_n = R_RESP;
          end else begin
            wait_cnt_n = 2'd1;
            r_state_n  = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (wait_cnt == RD_LAT) begin
          rdata_n   = AXI_Read_data;
          rresp_n   = RESP_OKAY;
          rvalid_n  = 1'b1;
          r_state_n = R_RESP;
        end else begin
          wait_cnt_n = wait_cnt + 2'd1;
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          rvalid_n  = 1'b0;
          r_state_n = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
    arready_n = (r_state_n == R_IDLE);
  end

  // Read FSM registers
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_state   <= R_IDLE;
      raddr_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      wait_cnt  <= '0;
    end else begin
      r_state   <= r_state_n;
      raddr_q   <= raddr_n;
      arready_q <= arready_n;
      rvalid_q  <= rvalid_n;
      rresp_q   <= rresp_n;
      rdata_q   <= rdata_n;
      wait_cnt  <= wait_cnt_n;
    end
  end

  // MMIO register writes: CTRL reset bit and coherent counter snapshot
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      mips_rst_q <= 1'b1;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        shadow[i] <= '0;
      end
    end else if (w_mmio_go) begin
      if (w_hit_ctrl && wstrb_q[0]) begin
        mips_rst_q <= ~wdata_q[0];
      end
      if (w_hit_snap && wstrb_q[0] && wdata_q[0]) begin
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
          shadow[i] <= cnt_bus[i*CNT_WIDTH +: CNT_WIDTH];
        end
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign mips_rst      = mips_rst_q;

endmodule
